muldiv_ctrl: RTL and testbench

Issue/completion controller for the shared floating-point multiply/divide unit. Accepts operations from two requesters over valid/ready handshakes, arbitrates round-robin and issues one operation at a time. Counts the unit's fixed latency per operation type, then pulses a result-capture strobe for the wrapper's result register. Presents the completed result with tag and source on a valid/ready output port.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_ctrl_rr_arb2.sv | 33 +++
 rtl/muldiv_ctrl.sv | 126 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the multiply/divide issue controller.
// Contents: FSM state enum, latched operation-control struct, latency-select function.
// No ports; imported by muldiv_ctrl and rr_arb2.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Latency counter width; every configured latency must fit below 2**CNT_W.
  localparam int CNT_W = 8;

  // Operation controls captured at issue. The requester tag lives beside this
  // in the controller because its width is chosen per instance.
  typedef struct packed {
    logic fdiv;
    logic db;
    logic src;
  } op_t;

  // Unit latency for an operation: multiply, double divide or single divide.
  function automatic logic [CNT_W-1:0] lat_sel(input logic fdiv, input logic db,
                                               input int mul_lat, input int div_lat_d,
                                               input int div_lat_s);
    int l;
    if (!fdiv)   l = mul_lat;
    else if (db) l = div_lat_d;
    else         l = div_lat_s;
    return CNT_W'(l);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a single priority pointer.
// Ports: clk/rst, valid0/valid1 requests, update (a grant was taken this cycle),
//        ready0/ready1 eligibility (never a function of the requester's own valid), grant index.
module rr_arb2
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  output logic ready0,
  output logic ready1,
  output logic grant
);

  logic ptr;

  // A requester is eligible when it holds priority or the other one is idle.
  // With both valid only the pointer's requester is eligible, so at most one
  // handshake can occur per cycle.
  assign ready0 = !ptr || !valid1;
  assign ready1 = ptr || !valid0;
  assign grant  = (valid0 && ready0) ? 1'b0 : 1'b1;

  // After any grant the other requester gets priority (covers both the
  // contended flip and the single-requester "loser" rule).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (update) ptr <= ~grant;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issue/completion controller for the shared FP multiply/divide unit.
// Ports: two req valid/ready ports (fdiv, db, tag), unit_start/unit_sel/unit_fdiv/unit_db to the
//        unit, res_load strobe, res valid/ready port (tag, src, fdiv), busy. Latency: start is
//        combinational on accept, res_load LAT cycles later, res_valid one cycle after that.
//        Optional MULDIV_CTRL_FAST_ISSUE_EN: accept a new op in the same cycle the result is consumed.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT_D = 14,
  parameter int DIV_LAT_S = 8,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_fdiv,
  input  logic             req0_db,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_fdiv,
  input  logic             req1_db,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             unit_start,
  output logic             unit_sel,
  output logic             unit_fdiv,
  output logic             unit_db,
  output logic             res_load,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic             res_fdiv,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  op_t              op;
  logic [TAG_W-1:0] op_tag;

  logic             arb_ready0, arb_ready1, grant;
  logic             can_accept, accept, consume;
  logic             sel_fdiv, sel_db;
  logic [TAG_W-1:0] sel_tag;

  assign consume = res_valid && res_ready;

  // Reset gates ready so nothing can be issued while rst is held.
`ifdef MULDIV_CTRL_FAST_ISSUE_EN
  assign can_accept = !rst && ((state == IDLE) || (state == HOLD && consume));
`else
  assign can_accept = !rst && (state == IDLE);
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .update (accept),
    .ready0 (arb_ready0),
    .ready1 (arb_ready1),
    .grant  (grant)
  );

  assign req0_ready = can_accept && arb_ready0;
  assign req1_ready = can_accept && arb_ready1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_fdiv = grant ? req1_fdiv : req0_fdiv;
  assign sel_db   = grant ? req1_db   : req0_db;
  assign sel_tag  = grant ? req1_tag  : req0_tag;

  assign unit_start = accept;
  assign unit_sel   = accept & grant;
  assign unit_fdiv  = op.fdiv;
  assign unit_db    = op.db;
  assign res_tag    = op_tag;
  assign res_src    = op.src;
  assign res_fdiv   = op.fdiv;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      op_tag    <= '0;
      res_load  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_load <= 1'b0;
      if (accept) begin
        op     <= '{fdiv: sel_fdiv, db: sel_db, src: grant};
        op_tag <= sel_tag;
        cnt    <= lat_sel(sel_fdiv, sel_db, MUL_LAT, DIV_LAT_D, DIV_LAT_S) - CNT_W'(1);
      end
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          // Counter was loaded with LAT-1, so reaching 1 lands res_load on issue+LAT.
          if (cnt == CNT_W'(1)) begin
            res_load <= 1'b1;
            cnt      <= '0;
            state    <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          // The result register is only valid the cycle after the capture strobe.
          if (res_load) res_valid <= 1'b1;
          if (consume) begin
            res_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int MUL_LAT   = 4;
  localparam int DIV_LAT_D = 14;
  localparam int DIV_LAT_S = 8;
  localparam int TAG_W     = 3;
`ifdef MULDIV_CTRL_FAST_ISSUE_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req0_fdiv = 1'b0, req0_db = 1'b0;
  logic req1_valid = 1'b0, req1_fdiv = 1'b0, req1_db = 1'b0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic res_ready = 1'b0;
  logic req0_ready, req1_ready, unit_start, unit_sel, unit_fdiv, unit_db;
  logic res_load, res_valid, res_src, res_fdiv, busy;
  logic [TAG_W-1:0] res_tag;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT_D(DIV_LAT_D), .DIV_LAT_S(DIV_LAT_S), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fdiv(req0_fdiv), .req0_db(req0_db), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fdiv(req1_fdiv), .req1_db(req1_db), .req1_tag(req1_tag),
    .unit_start(unit_start), .unit_sel(unit_sel), .unit_fdiv(unit_fdiv), .unit_db(unit_db),
    .res_load(res_load), .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_src(res_src), .res_fdiv(res_fdiv), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mptr = 1'b0;  // expected arbiter priority (reference model)

  always @(posedge clk) cyc = cyc + 1;

  // Event log sampled on the falling edge.
  int st_cyc[$];
  bit st_sel[$];
  int ld_cyc[$];
  int rv_cyc[$];
  int cons_cyc[$];
  logic [TAG_W-1:0] cons_tag[$];
  bit cons_src[$];
  bit cons_fdiv[$];

  always @(negedge clk) begin
    if (unit_start) begin st_cyc.push_back(cyc); st_sel.push_back(unit_sel); end
    if (res_load) ld_cyc.push_back(cyc);
    if (res_valid) rv_cyc.push_back(cyc);
    if (res_valid && res_ready) begin
      cons_cyc.push_back(cyc); cons_tag.push_back(res_tag);
      cons_src.push_back(res_src); cons_fdiv.push_back(res_fdiv);
    end
  end

  function automatic int model_lat(bit fd, bit d);
    if (!fd) return MUL_LAT;
    return d ? DIV_LAT_D : DIV_LAT_S;
  endfunction

  task automatic clear_logs();
    st_cyc.delete(); st_sel.delete(); ld_cyc.delete(); rv_cyc.delete();
    cons_cyc.delete(); cons_tag.delete(); cons_src.delete(); cons_fdiv.delete();
  endtask

  // Present one request and hold it until the handshake is seen.
  task automatic issue(input bit s, input bit fd, input bit d, input logic [TAG_W-1:0] t);
    int n = 0;
    bit rdy;
    @(posedge clk); #1;
    if (!s) begin req0_valid = 1; req0_fdiv = fd; req0_db = d; req0_tag = t; end
    else    begin req1_valid = 1; req1_fdiv = fd; req1_db = d; req1_tag = t; end
    do begin
      @(negedge clk); n++;
      rdy = s ? req1_ready : req0_ready;
    end while (!rdy && n < 100);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    if (!rdy) begin
      total++; bad++;
      $display("FAIL issue_timeout src=%0d got ready=0 want=1", s);
    end
    mptr = !s;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || res_valid) && n < 200);
    @(posedge clk); #1;
    if (busy || res_valid) begin
      total++; bad++;
      $display("FAIL idle_timeout got busy=%0b res_valid=%0b want 0 0", busy, res_valid);
    end
  endtask

  function automatic logic [TAG_W+10:0] outs();
    return {req0_ready, req1_ready, unit_start, unit_sel, unit_fdiv, unit_db,
            res_load, res_valid, res_tag, res_src, res_fdiv, busy};
  endfunction

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; res_ready = 1;
    repeat (2) @(posedge clk); #1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_outputs got=%b want=0", outs()); end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1; rst = 0; mptr = 0;
    @(negedge clk);
    total++;
    if ({busy, req0_ready, req1_ready} !== 3'b011) begin
      bad++; $display("FAIL idle_ready got=%b want=011", {busy, req0_ready, req1_ready});
    end
  endtask

  task automatic test_mul();
    res_ready = 1; clear_logs();
    issue(0, 0, 0, 3'd5);
    wait_idle();
    total++;
    if ({st_cyc.size(), ld_cyc.size(), rv_cyc.size(), cons_cyc.size()} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL mul_counts got st=%0d ld=%0d rv=%0d cons=%0d want 1 1 1 1",
                      st_cyc.size(), ld_cyc.size(), rv_cyc.size(), cons_cyc.size());
    end else begin
      total++;
      if (ld_cyc[0] - st_cyc[0] !== MUL_LAT) begin
        bad++; $display("FAIL mul_load_lat got=%0d want=%0d", ld_cyc[0] - st_cyc[0], MUL_LAT);
      end
      total++;
      if (rv_cyc[0] - st_cyc[0] !== MUL_LAT + 1) begin
        bad++; $display("FAIL mul_valid_lat got=%0d want=%0d", rv_cyc[0] - st_cyc[0], MUL_LAT + 1);
      end
      total++;
      if ({cons_tag[0], cons_src[0], cons_fdiv[0], st_sel[0]} !== {3'd5, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL mul_result got tag=%0d src=%0d fdiv=%0d sel=%0d want 5 0 0 0",
                        cons_tag[0], cons_src[0], cons_fdiv[0], st_sel[0]);
      end
    end
  endtask

  task automatic test_div();
    bit srcs[2] = '{1'b1, 1'b0};
    bit dbs[2]  = '{1'b1, 1'b0};
    logic [TAG_W-1:0] tags[2] = '{3'd2, 3'd7};
    for (int k = 0; k < 2; k++) begin
      int herr = 0;
      int n = 0;
      res_ready = 1; clear_logs();
      issue(srcs[k], 1, dbs[k], tags[k]);
      do begin
        @(negedge clk); n++;
        if (unit_db !== dbs[k] || unit_fdiv !== 1'b1) herr++;
      end while (!res_load && n < 40);
      wait_idle();
      total++;
      if (herr !== 0) begin bad++; $display("FAIL div_ctrl_held case=%0d got errors=%0d want=0", k, herr); end
      total++;
      if (ld_cyc.size() !== 1 || st_cyc.size() !== 1 || cons_cyc.size() !== 1) begin
        bad++; $display("FAIL div_counts case=%0d got st=%0d ld=%0d cons=%0d want 1 1 1",
                        k, st_cyc.size(), ld_cyc.size(), cons_cyc.size());
      end else if (ld_cyc[0] - st_cyc[0] !== model_lat(1, dbs[k]) || cons_src[0] !== srcs[k] ||
                   cons_tag[0] !== tags[k] || cons_fdiv[0] !== 1'b1) begin
        bad++; $display("FAIL div_result case=%0d got lat=%0d src=%0d tag=%0d want lat=%0d src=%0d tag=%0d",
                        k, ld_cyc[0] - st_cyc[0], cons_src[0], cons_tag[0],
                        model_lat(1, dbs[k]), srcs[k], tags[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int serr = 0;
    int gerr = 0;
    int terr = 0;
    bit first = mptr;
    res_ready = 1; clear_logs();
    @(posedge clk); #1;
    req0_valid = 1; req0_fdiv = 0; req0_db = 0; req0_tag = 3'd1;
    req1_valid = 1; req1_fdiv = 0; req1_db = 0; req1_tag = 3'd2;
    do begin @(negedge clk); #1; n++; end while (st_cyc.size() < 5 && n < 200);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    total++;
    if (st_cyc.size() !== 5 || cons_cyc.size() !== 5) begin
      bad++; $display("FAIL b2b_counts got st=%0d cons=%0d want 5 5", st_cyc.size(), cons_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (st_sel[i] !== (first ^ i[0])) gerr++;
        if (i > 0 && st_cyc[i] - st_cyc[i-1] !== MUL_LAT + 2 - FAST) serr++;
        if (cons_src[i] !== st_sel[i] || cons_tag[i] !== (cons_src[i] ? 3'd2 : 3'd1)) terr++;
      end
      total++;
      if (gerr !== 0) begin bad++; $display("FAIL b2b_alternate got errors=%0d want=0 first=%0d", gerr, first); end
      total++;
      if (serr !== 0) begin
        bad++; $display("FAIL b2b_spacing got gap=%0d want=%0d", st_cyc[1] - st_cyc[0], MUL_LAT + 2 - FAST);
      end
      total++;
      if (terr !== 0) begin bad++; $display("FAIL b2b_results got errors=%0d want=0", terr); end
      mptr = !(first ^ 1'b0);  // five grants: last one matches the first
    end
  endtask

  task automatic test_hold_stall();
    int n = 0;
    int verr = 0;
    int rerr = 0;
    res_ready = 0; clear_logs();
    issue(0, 1, 0, 3'd6);
    @(posedge clk); #1;
    req1_valid = 1; req1_fdiv = 0; req1_db = 0; req1_tag = 3'd3;
    do begin @(negedge clk); n++; end while (!res_valid && n < 50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_tag !== 3'd6 || res_src !== 1'b0) verr++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || unit_start !== 1'b0) rerr++;
    end
    total++;
    if (verr !== 0) begin bad++; $display("FAIL stall_result_held got errors=%0d want=0", verr); end
    total++;
    if (rerr !== 0) begin bad++; $display("FAIL stall_no_issue got errors=%0d want=0", rerr); end
    @(posedge clk); #1;
    res_ready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!unit_start && n < 10);
    @(posedge clk); #1;
    req1_valid = 0;
    mptr = 0;
    wait_idle();
    total++;
    if (st_cyc.size() !== 2 || cons_cyc.size() !== 2) begin
      bad++; $display("FAIL stall_counts got st=%0d cons=%0d want 2 2", st_cyc.size(), cons_cyc.size());
    end else begin
      total++;
      if (st_cyc[1] - cons_cyc[0] !== 1 - FAST || st_sel[1] !== 1'b1) begin
        bad++; $display("FAIL stall_reissue got gap=%0d sel=%0d want gap=%0d sel=1",
                        st_cyc[1] - cons_cyc[0], st_sel[1], 1 - FAST);
      end
      total++;
      if (cons_tag[0] !== 3'd6 || cons_tag[1] !== 3'd3 || cons_src[1] !== 1'b1) begin
        bad++; $display("FAIL stall_tags got %0d/%0d src=%0d want 6/3 src=1", cons_tag[0], cons_tag[1], cons_src[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1;
    issue(1, 1, 1, 3'd4);
    @(posedge clk); #1;
    rst = 1;
    #1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_mid_outputs got=%b want=0", outs()); end
    @(posedge clk); #1;
    rst = 0; mptr = 0;
    clear_logs();
    repeat (25) @(posedge clk); #1;
    total++;
    if (ld_cyc.size() !== 0 || rv_cyc.size() !== 0 || st_cyc.size() !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_dropped got ld=%0d rv=%0d st=%0d busy=%0b want 0 0 0 0",
                      ld_cyc.size(), rv_cyc.size(), st_cyc.size(), busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      bit s = 1'($urandom_range(0, 1));
      bit fd = 1'($urandom_range(0, 1));
      bit d = 1'($urandom_range(0, 1));
      logic [TAG_W-1:0] t = TAG_W'($urandom_range(0, 7));
      int k = $urandom_range(0, 3);
      int n = 0;
      clear_logs();
      res_ready = (k == 0);
      issue(s, fd, d, t);
      if (k != 0) begin
        do begin @(negedge clk); n++; end while (!res_valid && n < 40);
        repeat (k) @(posedge clk);
        #1; res_ready = 1;
      end
      wait_idle();
      total++;
      if (st_cyc.size() !== 1 || ld_cyc.size() !== 1 || cons_cyc.size() !== 1) begin
        bad++; $display("FAIL rand_counts it=%0d got st=%0d ld=%0d cons=%0d want 1 1 1",
                        it, st_cyc.size(), ld_cyc.size(), cons_cyc.size());
      end else if (ld_cyc[0] - st_cyc[0] !== model_lat(fd, d) || cons_cyc[0] - ld_cyc[0] !== 1 + k ||
                   st_sel[0] !== s || cons_src[0] !== s || cons_tag[0] !== t || cons_fdiv[0] !== fd) begin
        bad++; $display("FAIL rand_op it=%0d got lat=%0d wait=%0d src=%0d tag=%0d fdiv=%0d want lat=%0d wait=%0d src=%0d tag=%0d fdiv=%0d",
                        it, ld_cyc[0] - st_cyc[0], cons_cyc[0] - ld_cyc[0], cons_src[0], cons_tag[0], cons_fdiv[0],
                        model_lat(fd, d), 1 + k, s, t, fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_hold_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
